// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-detection bundle between the decode stage and the stall controller.
// The master side supplies register/hazard information; the slave side returns pipeline enables.
interface pipe_stall_ctrl_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic [4:0] a3_E;
    logic [4:0] a3_M;
    logic [1:0] tnew_E;
    logic [1:0] tnew_M;
    logic       md_start_E;
    logic       md_is_div_E;
    logic       md_use_D;
    logic       eret_D;
    logic       mtc0_epc_E;
    logic       mtc0_epc_M;
    logic       req;
    logic       en_pc;
    logic       en_d;
    logic       clr_e;
    logic       flush_all;
    logic       md_busy;
    logic [3:0] md_count;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_E, a3_M, tnew_E, tnew_M,
        output md_start_E, md_is_div_E, md_use_D, eret_D, mtc0_epc_E, mtc0_epc_M, req,
        input  en_pc, en_d, clr_e, flush_all, md_busy, md_count
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_E, a3_M, tnew_E, tnew_M,
        input  md_start_E, md_is_div_E, md_use_D, eret_D, mtc0_epc_E, mtc0_epc_M, req,
        output en_pc, en_d, clr_e, flush_all, md_busy, md_count
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard/stall controller: data-hazard stalls, MDU busy countdown, eret/EPC
// interlock, and whole-pipe flush on exception or interrupt.
module pipe_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic              clk,
    input logic              reset,
    pipe_stall_ctrl_if.slave bus
);

    localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
    localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

    logic [3:0] md_count_q;
    logic [3:0] md_count_d;
    logic       md_busy;
    logic       stall_rs;
    logic       stall_rt;
    logic       stall_md;
    logic       stall_eret;
    logic       stall;

    assign md_busy = (md_count_q != 4'd0);

    // A tuse of 3 can never be exceeded by a 2-bit tnew, so unused operands drop out naturally.
    always_comb begin
        stall_rs   = (bus.rs_D != 5'd0) &&
                     (((bus.a3_E == bus.rs_D) && (bus.tnew_E > bus.tuse_rs_D)) ||
                      ((bus.a3_M == bus.rs_D) && (bus.tnew_M > bus.tuse_rs_D)));
        stall_rt   = (bus.rt_D != 5'd0) &&
                     (((bus.a3_E == bus.rt_D) && (bus.tnew_E > bus.tuse_rt_D)) ||
                      ((bus.a3_M == bus.rt_D) && (bus.tnew_M > bus.tuse_rt_D)));
        stall_md   = bus.md_use_D && (md_busy || bus.md_start_E);
        stall_eret = bus.eret_D && (bus.mtc0_epc_E || bus.mtc0_epc_M);
        stall      = stall_rs || stall_rt || stall_md || stall_eret;
    end

    always_comb begin
        bus.en_pc     = !stall;
        bus.en_d      = !stall;
        bus.clr_e     = stall;
        bus.flush_all = 1'b0;
        if (bus.req) begin
            bus.en_pc     = 1'b1;
            bus.en_d      = 1'b1;
            bus.clr_e     = 1'b1;
            bus.flush_all = 1'b1;
        end
    end

    // A flushed mult/div must not start the countdown; a fresh start reloads even while busy.
    always_comb begin
        md_count_d = md_count_q;
        if (bus.md_start_E && !bus.req) begin
            md_count_d = bus.md_is_div_E ? DIV_N : MULT_N;
        end else if (md_busy) begin
            md_count_d = md_count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_count_q <= 4'd0;
        end else begin
            md_count_q <= md_count_d;
        end
    end

    assign bus.md_busy  = md_busy;
    assign bus.md_count = md_count_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed hazard/MDU/exception scenarios,
// a cycle-level reference model compared every negedge, plus literal spot checks.
module tb_pipe_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   checking = 1'b0;

    // Model: cycle index and the cycle at which the MDU becomes free again.
    int cyc    = 0;
    int doneAt = 0;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit operandStalls(input int rs, input int tuse);
        return (rs != 0) &&
               (((int'(bus.a3_E) == rs) && (int'(bus.tnew_E) > tuse)) ||
                ((int'(bus.a3_M) == rs) && (int'(bus.tnew_M) > tuse)));
    endfunction

    function automatic int modelCount();
        return (doneAt > cyc) ? doneAt - cyc : 0;
    endfunction

    function automatic bit modelStall();
        bit busy;
        busy = (modelCount() != 0);
        return operandStalls(int'(bus.rs_D), int'(bus.tuse_rs_D)) ||
               operandStalls(int'(bus.rt_D), int'(bus.tuse_rt_D)) ||
               (bus.md_use_D && (busy || bus.md_start_E)) ||
               (bus.eret_D && (bus.mtc0_epc_E || bus.mtc0_epc_M));
    endfunction

    // The MDU is free N cycles after the edge that accepted a non-flushed start.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            doneAt = cyc;
        end else begin
            cyc = cyc + 1;
            if (bus.md_start_E && !bus.req) begin
                doneAt = cyc + (bus.md_is_div_E ? DIV_N : MULT_N);
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            bit st;
            st = modelStall();
            checkOutput("cmp_md_count",  int'(bus.md_count),  modelCount());
            checkOutput("cmp_md_busy",   int'(bus.md_busy),   int'(modelCount() != 0));
            checkOutput("cmp_en_pc",     int'(bus.en_pc),     bus.req ? 1 : int'(!st));
            checkOutput("cmp_en_d",      int'(bus.en_d),      bus.req ? 1 : int'(!st));
            checkOutput("cmp_clr_e",     int'(bus.clr_e),     bus.req ? 1 : int'(st));
            checkOutput("cmp_flush_all", int'(bus.flush_all), int'(bus.req));
        end
    end

    task automatic clearInputs();
        bus.rs_D        = '0;
        bus.rt_D        = '0;
        bus.tuse_rs_D   = 2'd3;
        bus.tuse_rt_D   = 2'd3;
        bus.a3_E        = '0;
        bus.a3_M        = '0;
        bus.tnew_E      = '0;
        bus.tnew_M      = '0;
        bus.md_start_E  = 1'b0;
        bus.md_is_div_E = 1'b0;
        bus.md_use_D    = 1'b0;
        bus.eret_D      = 1'b0;
        bus.mtc0_epc_E  = 1'b0;
        bus.mtc0_epc_M  = 1'b0;
        bus.req         = 1'b0;
    endtask

    // Advance to just after the next rising edge, then let combinational outputs settle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkEnables(input string tag, input int pc, input int d, input int clr, input int fl);
        #1;
        checkOutput({tag, "_en_pc"},     int'(bus.en_pc),     pc);
        checkOutput({tag, "_en_d"},      int'(bus.en_d),      d);
        checkOutput({tag, "_clr_e"},     int'(bus.clr_e),     clr);
        checkOutput({tag, "_flush_all"}, int'(bus.flush_all), fl);
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        bus.tuse_rs_D = 2'd0;
        bus.tuse_rt_D = 2'd0;
        applyStimulus();
        checkEnables("reset", 1, 1, 0, 0);
        checkOutput("reset_md_count", int'(bus.md_count), 0);
        checkOutput("reset_md_busy",  int'(bus.md_busy),  0);
        checking = 1'b1;
        reset = 1'b0;
        clearInputs();

        // Load-use through E, then the same producer has moved to M and is ready.
        applyStimulus();
        bus.a3_E = 5'd8; bus.tnew_E = 2'd2; bus.rs_D = 5'd8; bus.tuse_rs_D = 2'd1;
        checkEnables("loaduse", 0, 0, 1, 0);
        applyStimulus();
        bus.a3_E = 5'd0; bus.tnew_E = 2'd0; bus.a3_M = 5'd8; bus.tnew_M = 2'd1;
        checkEnables("loaduse_next", 1, 1, 0, 0);

        // Register 0 never stalls.
        applyStimulus();
        clearInputs();
        bus.rs_D = 5'd0; bus.a3_E = 5'd0; bus.tnew_E = 2'd2; bus.tuse_rs_D = 2'd0;
        checkEnables("zeroreg", 1, 1, 0, 0);

        // tuse = 3 never stalls; tnew 3 against tuse 2 does.
        applyStimulus();
        clearInputs();
        bus.a3_E = 5'd9; bus.tnew_E = 2'd3; bus.rt_D = 5'd9; bus.tuse_rt_D = 2'd3;
        checkEnables("tuse3", 1, 1, 0, 0);
        applyStimulus();
        bus.tuse_rt_D = 2'd2;
        checkEnables("tnew3_tuse2", 0, 0, 1, 0);

        // rt hazard against the M stage.
        applyStimulus();
        clearInputs();
        bus.rt_D = 5'd5; bus.a3_M = 5'd5; bus.tnew_M = 2'd2; bus.tuse_rt_D = 2'd1;
        checkEnables("rt_m", 0, 0, 1, 0);

        // Divide: dependent MDU op stalls in the start cycle plus 10 busy cycles.
        applyStimulus();
        clearInputs();
        bus.md_start_E = 1'b1; bus.md_is_div_E = 1'b1; bus.md_use_D = 1'b1;
        checkEnables("div_start", 0, 0, 1, 0);
        for (int i = DIV_N; i >= 1; i--) begin
            applyStimulus();
            bus.md_start_E = 1'b0; bus.md_is_div_E = 1'b0;
            #1;
            checkOutput("div_count", int'(bus.md_count), i);
            checkOutput("div_en_d",  int'(bus.en_d),     0);
        end
        applyStimulus();
        #1;
        checkOutput("div_done_count", int'(bus.md_count), 0);
        checkOutput("div_done_en_d",  int'(bus.en_d),     1);

        // Exception outranks a data stall and suppresses the MDU load.
        applyStimulus();
        clearInputs();
        bus.md_start_E = 1'b1; bus.req = 1'b1;
        bus.a3_E = 5'd8; bus.tnew_E = 2'd2; bus.rs_D = 5'd8; bus.tuse_rs_D = 2'd1;
        checkEnables("exc", 1, 1, 1, 1);
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("exc_no_load", int'(bus.md_count), 0);

        // Exception during a countdown: decrement continues, no reload.
        applyStimulus();
        bus.md_start_E = 1'b1;
        applyStimulus();
        bus.md_start_E = 1'b1; bus.req = 1'b1;
        #1;
        checkOutput("excmid_count_before", int'(bus.md_count), MULT_N);
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("excmid_count_after", int'(bus.md_count), MULT_N - 1);

        // A new start reloads even while busy.
        applyStimulus();
        bus.md_start_E = 1'b1; bus.md_is_div_E = 1'b1;
        applyStimulus();
        bus.md_is_div_E = 1'b0;
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("reload_count", int'(bus.md_count), MULT_N);
        repeat (MULT_N + 1) applyStimulus();

        // eret waits for an in-flight EPC write.
        bus.eret_D = 1'b1; bus.mtc0_epc_M = 1'b1;
        checkEnables("eret_m", 0, 0, 1, 0);
        applyStimulus();
        bus.mtc0_epc_M = 1'b0; bus.mtc0_epc_E = 1'b1;
        checkEnables("eret_e", 0, 0, 1, 0);
        applyStimulus();
        bus.mtc0_epc_E = 1'b0;
        checkEnables("eret_free", 1, 1, 0, 0);

        // Asynchronous reset in the middle of a mult countdown.
        applyStimulus();
        clearInputs();
        bus.md_start_E = 1'b1;
        applyStimulus();
        clearInputs();
        applyStimulus();
        applyStimulus();
        #1;
        checkOutput("midreset_before", int'(bus.md_count), 3);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_count", int'(bus.md_count), 0);
        checkOutput("midreset_busy",  int'(bus.md_busy),  0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        repeat (3) applyStimulus();

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
